// File: rtl/psram_bus_arb_pkg.sv
// Shared types and constants for the PSRAM bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package psram_bus_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY   = 3'd1,
    ERR    = 3'd2,
    RESP   = 3'd3,
    LOCKED = 3'd4
  } state_t;

  // Default chip-select count and the width of the chip index field.
  localparam int NCS_DEF = 4;
  localparam int CSW     = $clog2(NCS_DEF);

  // Read data returned for requests to unpopulated chips.
  localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/psram_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when to act on the pick.
module psram_rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);

  logic [PW:0]   sum;
  logic [PW-1:0] cand;

  // Walk the requesters starting at ptr and latch the first one that is set.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = '0;
    cand = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      cand = sum[PW-1:0];
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/psram_bus_arb.sv
// Round-robin arbiter sharing one PSRAM controller port; one transaction in flight.
// Latency: request -> mem_valid_o next cycle; mem_ready_i -> req_ready_o next cycle; bad chip -> ready at +2.
// Backpressure: requesters hold valid until the one-cycle ready pulse; controller stalls by withholding mem_ready_i.
module psram_bus_arb
  import psram_bus_arb_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int AW       = 23,
  parameter int NCS      = 1 << CSW,
  parameter int NCS_EN   = 1,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [NREQ-1:0]   req_lock_i,
  input  logic [NREQ*32-1:0] req_addr_i,
  input  logic [NREQ*32-1:0] req_wdata_i,
  input  logic [NREQ*4-1:0] req_wstrb_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [31:0]       req_rdata_o,
  output logic [NREQ-1:0]   req_err_o,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [AW-1:0]     mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_wstrb_o,
  output logic [NCS-1:0]    mem_cs_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (NCS > 1) ? $clog2(NCS) : 1;
  localparam int LW = $clog2(MAX_LOCK + 1);
  localparam logic [NCS-1:0] CS_ONE = NCS'(1);

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   g;
  logic [NREQ-1:0] g_oh;
  logic [LW-1:0]   lock_cnt;
  logic [PW-1:0]   nxt_ptr;

  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;

  logic [31:0] addr_a  [NREQ];
  logic [31:0] wdata_a [NREQ];
  logic [3:0]  wstrb_a [NREQ];

  logic            take;
  logic [PW-1:0]   sel;
  logic [NREQ-1:0] sel_oh;
  logic [31:0]     sel_addr;
  logic [31:0]     sel_wdata;
  logic [3:0]      sel_wstrb;
  logic [CW-1:0]   sel_cidx;
  logic            sel_oor;
  logic            unused_addr_hi;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr_i[i*32 +: 32];
    assign wdata_a[i] = req_wdata_i[i*32 +: 32];
    assign wstrb_a[i] = req_wstrb_i[i*4 +: 4];
  end

  psram_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req (req_valid_i),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign nxt_ptr = (g == PW'(NREQ - 1)) ? '0 : g + 1'b1;

  // Choose the request to accept: round-robin pick in IDLE, only the lock holder in LOCKED.
  always_comb begin
    sel       = (state == LOCKED) ? g : pick_idx;
    sel_oh    = (state == LOCKED) ? g_oh : pick_gnt;
    take      = ((state == IDLE) && pick_any) || ((state == LOCKED) && req_valid_i[g]);
    sel_addr  = addr_a[sel];
    sel_wdata = wdata_a[sel];
    sel_wstrb = wstrb_a[sel];
    sel_cidx  = sel_addr[AW+CW-1:AW];
    sel_oor   = 32'(sel_cidx) >= 32'(NCS_EN);
  end

  // Address bits above the chip field carry no meaning for the PSRAM.
  assign unused_addr_hi = ^sel_addr[31:AW+CW];

  // Arbitration / sequencing FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ptr         <= '0;
      g           <= '0;
      g_oh        <= '0;
      lock_cnt    <= '0;
      mem_valid_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_wstrb_o <= '0;
      mem_cs_o    <= '0;
      req_ready_o <= '0;
      req_err_o   <= '0;
      req_rdata_o <= '0;
    end else begin
      req_ready_o <= '0;
      req_err_o   <= '0;
      req_rdata_o <= '0;
      case (state)
        IDLE, LOCKED: begin
          if (take) begin
            g    <= sel;
            g_oh <= sel_oh;
            if (sel_oor) begin
              state <= ERR;
            end else begin
              state       <= BUSY;
              mem_valid_o <= 1'b1;
              mem_addr_o  <= sel_addr[AW-1:0];
              mem_wdata_o <= sel_wdata;
              mem_wstrb_o <= sel_wstrb;
              mem_cs_o    <= CS_ONE << sel_cidx;
            end
          end else if ((state == LOCKED) && !req_lock_i[g]) begin
            state    <= IDLE;
            ptr      <= nxt_ptr;
            lock_cnt <= '0;
          end
        end
        BUSY: begin
          if (mem_ready_i) begin
            mem_valid_o <= 1'b0;
            mem_cs_o    <= '0;
            req_ready_o <= g_oh;
            req_rdata_o <= mem_rdata_i;
            state       <= RESP;
          end
        end
        ERR: begin
          req_ready_o <= g_oh;
          req_err_o   <= g_oh;
          req_rdata_o <= ERR_RDATA;
          state       <= RESP;
        end
        RESP: begin
          if (req_lock_i[g] && (lock_cnt < LW'(MAX_LOCK - 1))) begin
            lock_cnt <= lock_cnt + 1'b1;
            state    <= LOCKED;
          end else begin
            lock_cnt <= '0;
            ptr      <= nxt_ptr;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_bus_arb.sv
// Directed bench for psram_bus_arb: arbitration order, locking, decode errors, stalls, reset.
// Latency: checks the 1-cycle issue and 1-cycle completion paths cycle by cycle.
// Backpressure: models a controller that stalls or answers in one cycle.
module tb_psram_bus_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid, req_lock, req_ready, req_err;
  logic [95:0] req_addr, req_wdata;
  logic [11:0] req_wstrb;
  logic [31:0] req_rdata;
  logic        mem_valid, mem_ready;
  logic [22:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb, mem_cs;

  int n_checks = 0;
  int n_fail   = 0;

  psram_bus_arb dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_lock_i  (req_lock),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_wstrb_i (req_wstrb),
    .req_ready_o (req_ready),
    .req_rdata_o (req_rdata),
    .req_err_o   (req_err),
    .mem_valid_o (mem_valid),
    .mem_ready_i (mem_ready),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_wstrb_o (mem_wstrb),
    .mem_cs_o    (mem_cs),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0; req_lock = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 3'b111; req_lock = 3'b111; req_addr = {3{32'h0000_0100}};
    req_wdata = {3{32'hFFFF_FFFF}}; req_wstrb = 12'hFFF; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step(); step();
    n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset mem_valid: got %b want 0", mem_valid); end
    n_checks++; if (mem_cs !== 4'b0) begin n_fail++; $display("FAIL reset mem_cs: got %b want 0000", mem_cs); end
    n_checks++; if (mem_addr !== 23'h0) begin n_fail++; $display("FAIL reset mem_addr: got %h want 0", mem_addr); end
    n_checks++; if (mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin n_fail++; $display("FAIL reset mem_wdata/wstrb: got %h/%h want 0/0", mem_wdata, mem_wstrb); end
    n_checks++; if (req_ready !== 3'b0 || req_err !== 3'b0) begin n_fail++; $display("FAIL reset ready/err: got %b/%b want 000/000", req_ready, req_err); end
    n_checks++; if (req_rdata !== 32'h0) begin n_fail++; $display("FAIL reset req_rdata: got %h want 0", req_rdata); end
  endtask

  task automatic test_single_read();
    do_reset();
    req_valid = 3'b001; req_addr[31:0] = 32'h0000_0100;
    for (int c = 1; c <= 3; c++) begin
      step();
      n_checks++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL read mem_valid c%0d: got %b want 1", c, mem_valid); end
      n_checks++; if (mem_addr !== 23'h000100 || mem_cs !== 4'b0001) begin n_fail++; $display("FAIL read addr/cs c%0d: got %h/%b want 000100/0001", c, mem_addr, mem_cs); end
      n_checks++; if (req_ready !== 3'b0) begin n_fail++; $display("FAIL read early ready c%0d: got %b want 000", c, req_ready); end
      if (c == 3) begin mem_ready = 1'b1; mem_rdata = 32'h1234_5678; end
    end
    step();
    mem_ready = 1'b0; mem_rdata = 32'h0;
    n_checks++; if (req_ready !== 3'b001 || req_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL read resp c4: got %b/%h want 001/12345678", req_ready, req_rdata); end
    n_checks++; if (mem_valid !== 1'b0 || mem_cs !== 4'b0) begin n_fail++; $display("FAIL read idle c4: got %b/%b want 0/0000", mem_valid, mem_cs); end
    step();
    req_valid = 3'b000;
    n_checks++; if (req_ready !== 3'b0 || req_rdata !== 32'h0) begin n_fail++; $display("FAIL read c5 ready/rdata: got %b/%h want 000/0", req_ready, req_rdata); end
    n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL read reissue c5: got %b want 0", mem_valid); end
    step();
    n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL read reissue c6: got %b want 0", mem_valid); end
  endtask

  task automatic test_round_robin();
    int exp_order[6] = '{0, 1, 2, 0, 1, 2};
    int k = 0;
    int issued = 0;
    do_reset();
    req_addr = {32'h0000_0030, 32'h0000_0020, 32'h0000_0010};
    req_valid = 3'b111;
    for (int c = 0; c < 60 && k < 6; c++) begin
      step();
      mem_ready = 1'b0;
      if (req_ready !== 3'b0) begin
        n_checks++; if (req_ready !== (3'b001 << exp_order[k])) begin n_fail++; $display("FAIL rr grant #%0d: got %b want %b", k, req_ready, 3'b001 << exp_order[k]); end
        n_checks++; if (req_rdata !== 32'hD000_0000 + k) begin n_fail++; $display("FAIL rr rdata #%0d: got %h want %h", k, req_rdata, 32'hD000_0000 + k); end
        k++;
      end
      if (mem_valid === 1'b1 && issued < 6) begin
        n_checks++; if (mem_addr !== 23'(32'h10 * (exp_order[issued] + 1))) begin n_fail++; $display("FAIL rr addr #%0d: got %h want %h", issued, mem_addr, 32'h10 * (exp_order[issued] + 1)); end
        mem_ready = 1'b1; mem_rdata = 32'hD000_0000 + issued;
        issued++;
      end
    end
    n_checks++; if (k != 6) begin n_fail++; $display("FAIL rr timeout: got %0d completions want 6", k); end
    req_valid = 3'b000; mem_ready = 1'b0;
  endtask

  task automatic test_lock();
    int exp_order[6] = '{1, 1, 1, 1, 0, 1};
    int k = 0;
    int issued = 0;
    do_reset();
    req_addr = {32'h0000_0030, 32'h0000_0020, 32'h0000_0010};
    req_valid = 3'b010; req_lock = 3'b010;
    for (int c = 0; c < 80 && k < 6; c++) begin
      step();
      if (c == 0) req_valid = 3'b011;
      mem_ready = 1'b0;
      if (req_ready !== 3'b0) begin
        n_checks++; if (req_ready !== (3'b001 << exp_order[k])) begin n_fail++; $display("FAIL lock grant #%0d: got %b want %b", k, req_ready, 3'b001 << exp_order[k]); end
        k++;
      end
      if (mem_valid === 1'b1 && issued < 6) begin
        n_checks++; if (mem_addr !== 23'(32'h10 * (exp_order[issued] + 1))) begin n_fail++; $display("FAIL lock addr #%0d: got %h want %h", issued, mem_addr, 32'h10 * (exp_order[issued] + 1)); end
        mem_ready = 1'b1; mem_rdata = 32'hE000_0000 + issued;
        issued++;
      end
    end
    n_checks++; if (k != 6) begin n_fail++; $display("FAIL lock timeout: got %0d completions want 6", k); end
    req_valid = 3'b000; req_lock = 3'b000; mem_ready = 1'b0;
  endtask

  task automatic test_out_of_range();
    do_reset();
    mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    req_valid = 3'b100; req_addr[95:64] = 32'h0100_0000; req_wdata[95:64] = 32'hFFFF_FFFF; req_wstrb[11:8] = 4'hF;
    step();
    n_checks++; if (mem_valid !== 1'b0 || mem_cs !== 4'b0 || req_ready !== 3'b0) begin n_fail++; $display("FAIL oor c1: got valid %b cs %b ready %b want 0/0000/000", mem_valid, mem_cs, req_ready); end
    step();
    n_checks++; if (req_ready !== 3'b100 || req_err !== 3'b100) begin n_fail++; $display("FAIL oor c2 ready/err: got %b/%b want 100/100", req_ready, req_err); end
    n_checks++; if (req_rdata !== 32'h0 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL oor c2 rdata/valid: got %h/%b want 0/0", req_rdata, mem_valid); end
    step();
    req_valid = 3'b001; req_addr[31:0] = 32'h0080_0000;
    n_checks++; if (req_ready !== 3'b0 || req_err !== 3'b0 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL oor c3: got ready %b err %b valid %b want 000/000/0", req_ready, req_err, mem_valid); end
    step();
    n_checks++; if (mem_valid !== 1'b0 || req_err !== 3'b0) begin n_fail++; $display("FAIL oor idx1 c4: got valid %b err %b want 0/000", mem_valid, req_err); end
    step();
    n_checks++; if (req_ready !== 3'b001 || req_err !== 3'b001 || req_rdata !== 32'h0) begin n_fail++; $display("FAIL oor idx1 c5: got %b/%b/%h want 001/001/0", req_ready, req_err, req_rdata); end
    req_valid = 3'b000; mem_ready = 1'b0;
    step();
  endtask

  task automatic test_write_stall();
    int pulses = 0;
    do_reset();
    req_valid = 3'b001; req_addr[31:0] = 32'hFE00_0200; req_wdata[31:0] = 32'hCAFE_F00D; req_wstrb[3:0] = 4'b0011;
    for (int c = 1; c <= 10; c++) begin
      step();
      mem_rdata = $urandom;
      n_checks++; if (mem_valid !== 1'b1 || mem_cs !== 4'b0001) begin n_fail++; $display("FAIL stall c%0d valid/cs: got %b/%b want 1/0001", c, mem_valid, mem_cs); end
      n_checks++; if (mem_addr !== 23'h000200 || mem_wdata !== 32'hCAFE_F00D || mem_wstrb !== 4'b0011) begin n_fail++; $display("FAIL stall c%0d payload: got %h/%h/%b want 000200/cafef00d/0011", c, mem_addr, mem_wdata, mem_wstrb); end
      n_checks++; if (req_ready !== 3'b0) begin n_fail++; $display("FAIL stall c%0d early ready: got %b want 000", c, req_ready); end
      if (c == 10) begin mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA; end
    end
    step();
    mem_ready = 1'b0;
    n_checks++; if (req_ready !== 3'b001 || req_rdata !== 32'h5555_AAAA) begin n_fail++; $display("FAIL stall resp c11: got %b/%h want 001/5555aaaa", req_ready, req_rdata); end
    for (int c = 12; c <= 15; c++) begin
      step();
      if (c == 12) req_valid = 3'b000;
      if (req_ready !== 3'b0) pulses++;
    end
    n_checks++; if (pulses != 0 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL stall extra pulses: got %0d pulses valid %b want 0/0", pulses, mem_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_addr[63:32] = 32'h0000_0040; req_addr[31:0] = 32'h0000_0080;
    req_valid = 3'b010;
    step();
    req_valid = 3'b011;
    n_checks++; if (mem_valid !== 1'b1 || mem_addr !== 23'h000040) begin n_fail++; $display("FAIL rstmid c1: got %b/%h want 1/000040", mem_valid, mem_addr); end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (mem_valid !== 1'b0 || mem_cs !== 4'b0 || req_ready !== 3'b0) begin n_fail++; $display("FAIL rstmid c3: got valid %b cs %b ready %b want 0/0000/000", mem_valid, mem_cs, req_ready); end
    step();
    n_checks++; if (mem_valid !== 1'b1 || mem_addr !== 23'h000080) begin n_fail++; $display("FAIL rstmid c4 req0 first: got %b/%h want 1/000080", mem_valid, mem_addr); end
    mem_ready = 1'b1; mem_rdata = 32'h600D_0000;
    step();
    mem_ready = 1'b0;
    n_checks++; if (req_ready !== 3'b001 || req_rdata !== 32'h600D_0000) begin n_fail++; $display("FAIL rstmid c5: got %b/%h want 001/600d0000", req_ready, req_rdata); end
    step();
    req_valid = 3'b010;
    step();
    n_checks++; if (mem_valid !== 1'b1 || mem_addr !== 23'h000040) begin n_fail++; $display("FAIL rstmid c7 req1 next: got %b/%h want 1/000040", mem_valid, mem_addr); end
    req_valid = 3'b000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_out_of_range();
    test_write_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
